// File: rtl/reg_bridge_pkg.sv
// Shared types for the register access bridge: FSM state encoding and the
// queued command entry. Entry widths track the register set's 8-bit address/data.
package reg_bridge_pkg;

  localparam int REG_ADDR_W = 8;
  localparam int REG_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic                  wnr;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } cmd_entry_t;

  localparam int CMD_ENTRY_W = $bits(cmd_entry_t);

endpackage

// File: rtl/reg_cmd_fifo.sv
// Synchronous command FIFO, power-of-two depth; pointers carry one extra wrap
// bit so full and empty are distinguishable without a separate count.
module reg_cmd_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

  logic [IDX_W:0]   r_wr_ptr;
  logic [IDX_W:0]   r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                      (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
  assign w_do_push  = i_push && !o_full;
  assign w_do_pop   = i_pop && !o_empty;
  assign o_pop_data = r_mem[r_rd_ptr[IDX_W-1:0]];

  // Pointer update; simultaneous push and pop leave the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= {(IDX_W+1){1'b0}};
      r_rd_ptr <= {(IDX_W+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage write; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[IDX_W-1:0]] <= i_push_data;
    end
  end

endmodule

// File: rtl/reg_access_bridge.sv
// Host-to-register-set bridge: queues commands, replays each as one req pulse,
// waits for ack with a bounded timeout and returns one response per command.
module reg_access_bridge
  import reg_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_W,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wnr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  reg_wnr,
  output logic                  reg_req,
  output logic [ADDR_WIDTH-1:0] reg_address,
  output logic [DATA_WIDTH-1:0] reg_data_in,
  input  logic                  reg_ack,
  input  logic [DATA_WIDTH-1:0] reg_data_out
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  cmd_entry_t w_push_entry;
  cmd_entry_t w_pop_entry;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_req;
  logic                  r_wnr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_err;

  assign w_push_entry = '{wnr: cmd_wnr, addr: cmd_addr, data: cmd_data};
  assign cmd_ready    = !w_full && !reset;
  assign w_push       = cmd_valid && cmd_ready;
  assign w_pop        = (r_state == IDLE) && !w_empty;

  reg_cmd_fifo #(
    .WIDTH (CMD_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_pop_data  (w_pop_entry),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Access sequencer: pop, single req pulse, bounded ack wait, held response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_req       <= 1'b0;
      r_wnr       <= 1'b0;
      r_addr      <= {ADDR_WIDTH{1'b0}};
      r_wdata     <= {DATA_WIDTH{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= {DATA_WIDTH{1'b0}};
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_wnr   <= w_pop_entry.wnr;
            r_addr  <= w_pop_entry.addr;
            r_wdata <= w_pop_entry.data;
            r_req   <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_req   <= 1'b0;
          r_cnt   <= {CNT_W{1'b0}};
          r_state <= WAIT;
        end
        WAIT: begin
          // An ack in the expiry cycle still counts as a successful access.
          if (reg_ack) begin
            r_rsp_data  <= r_wnr ? {DATA_WIDTH{1'b0}} : reg_data_out;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_rsp_data  <= {DATA_WIDTH{1'b0}};
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_req       <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign reg_req     = r_req;
  assign reg_wnr     = r_wnr;
  assign reg_address = r_addr;
  assign reg_data_in = r_wdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_reg_access_bridge.sv
// Scoreboard bench for reg_access_bridge with a delay-programmable register-set model.
module tb_reg_access_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_wnr;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       reg_wnr;
  logic       reg_req;
  logic [7:0] reg_address;
  logic [7:0] reg_data_in;
  logic       reg_ack;
  logic [7:0] reg_data_out;

  int n_vec = 0;
  int n_err = 0;
  int n_rsp = 0;
  int req_count = 0;

  typedef struct packed {logic [7:0] data; logic err;} rsp_t;
  typedef struct packed {logic wnr; logic [7:0] addr; logic [7:0] data;} acc_t;
  rsp_t exp_q[$];
  acc_t acc_q[$];
  rsp_t e;
  acc_t a;
  logic prev_req = 1'b0;

  reg_access_bridge #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .FIFO_DEPTH (4),
    .TIMEOUT    (15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wnr      (cmd_wnr),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .reg_wnr      (reg_wnr),
    .reg_req      (reg_req),
    .reg_address  (reg_address),
    .reg_data_in  (reg_data_in),
    .reg_ack      (reg_ack),
    .reg_data_out (reg_data_out)
  );

  always #5 clk = ~clk;

  // Register-set model: unwritten locations read as addr ^ 0xA5; ack comes
  // ack_delay cycles after the req-sampling edge (0 = immediately after it).
  logic [7:0] mem [256];
  bit         written [256];
  bit         ack_en;
  int         ack_delay;
  int         ack_cd = 0;
  logic [7:0] pend_data;

  function automatic logic [7:0] rd_val(input logic [7:0] ad);
    return written[ad] ? mem[ad] : (ad ^ 8'hA5);
  endfunction

  always @(posedge clk) begin
    reg_ack <= 1'b0;
    if (ack_cd == 1) begin
      reg_ack      <= 1'b1;
      reg_data_out <= pend_data;
      ack_cd       <= 0;
    end else if (ack_cd > 1) begin
      ack_cd <= ack_cd - 1;
    end
    if (reg_req && ack_en) begin
      if (reg_wnr) begin
        mem[reg_address]     <= reg_data_in;
        written[reg_address] <= 1'b1;
      end
      if (ack_delay == 0) begin
        reg_ack      <= 1'b1;
        reg_data_out <= rd_val(reg_address);
      end else begin
        ack_cd    <= ack_delay;
        pend_data <= rd_val(reg_address);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor: every accepted response must match the queue head.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL extra_rsp: got data 0x%0h err %0b, required no response", rsp_data, rsp_err);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_err", rsp_err, e.err);
        n_rsp++;
      end
    end
  end

  // Access monitor: each req is a lone pulse carrying the next queued command.
  always @(negedge clk) begin
    if (reg_req) begin
      req_count <= req_count + 1;
      check("req_single", prev_req, 1'b0);
      if (acc_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL extra_req: got req to addr 0x%0h, required none", reg_address);
      end else begin
        a = acc_q.pop_front();
        check("acc_wnr", reg_wnr, a.wnr);
        check("acc_addr", reg_address, a.addr);
        if (a.wnr) check("acc_data", reg_data_in, a.data);
      end
    end
    prev_req <= reg_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic wnr, input logic [7:0] ad, input logic [7:0] d,
                      input logic [7:0] exp_d, input logic exp_e);
    int w;
    cmd_valid = 1'b1;
    cmd_wnr   = wnr;
    cmd_addr  = ad;
    cmd_data  = d;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: cmd_ready 0 for addr 0x%0h, required 1", ad);
    end else begin
      exp_q.push_back('{exp_d, exp_e});
      acc_q.push_back('{wnr, ad, d});
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  // Edges after the accept edge until rsp_valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    tick();
  endtask

  task automatic wait_drain(input string name);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || acc_q.size() != 0) && w < 500) begin
      tick();
      w++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1'b0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_data"}, rsp_data, 8'h00);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
    check({tag, "_reg_req"}, reg_req, 1'b0);
    check({tag, "_reg_wnr"}, reg_wnr, 1'b0);
    check({tag, "_reg_addr"}, reg_address, 8'h00);
    check({tag, "_reg_din"}, reg_data_in, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    int rc;
    int rs;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_wnr   = 1'b0;
    cmd_addr  = 8'h00;
    cmd_data  = 8'h00;
    rsp_ready = 1'b1;
    ack_en    = 1'b1;
    ack_delay = 0;
    repeat (3) tick();
    @(negedge clk);
    check_idle("rst");
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_init", cmd_ready, 1'b1);
    tick();

    // Write then read back, 3-cycle latency each
    send(1'b1, 8'h03, 8'h5A, 8'h00, 1'b0);
    wait_valid(n);
    check("lat_wr", n, 3);
    send(1'b0, 8'h03, 8'h00, 8'h5A, 1'b0);
    wait_valid(n);
    check("lat_rd", n, 3);
    wait_drain("drain_t1");
    check("req_count_t1", req_count, 2);

    // FIFO fill with the FSM stalled on a held response
    rs = n_rsp;
    rsp_ready = 1'b0;
    send(1'b1, 8'h20, 8'h99, 8'h00, 1'b0);
    wait_valid(n);
    for (int i = 1; i <= 4; i++) send(1'b1, 8'h20 + 8'(i), 8'(i * 17), 8'h00, 1'b0);
    @(negedge clk);
    check("ready_full", cmd_ready, 1'b0);
    tick();
    fork
      send(1'b1, 8'h25, 8'h55, 8'h00, 1'b0);
      begin
        repeat (5) begin
          @(negedge clk);
          check("ready_held", cmd_ready, 1'b0);
        end
        tick();
        rsp_ready = 1'b1;
      end
    join
    wait_drain("drain_t2");
    check("rsp_count_t2", n_rsp - rs, 6);

    // No ack at all: timeout error after 15 WAIT cycles, then normal service
    ack_en = 1'b0;
    send(1'b0, 8'h10, 8'h00, 8'h00, 1'b1);
    wait_valid(n);
    check("lat_timeout", n, 17);
    ack_en = 1'b1;
    send(1'b0, 8'h03, 8'h00, 8'h5A, 1'b0);
    wait_valid(n);
    check("lat_after_to", n, 3);

    // Ack in the final WAIT cycle wins; one cycle later is a timeout
    ack_delay = 14;
    send(1'b0, 8'h04, 8'h00, 8'hA1, 1'b0);
    wait_valid(n);
    check("lat_ack_last", n, 17);
    ack_delay = 15;
    send(1'b0, 8'h05, 8'h00, 8'h00, 1'b1);
    wait_valid(n);
    check("lat_ack_late", n, 17);
    wait_drain("drain_t4");
    rs = n_rsp;
    rc = req_count;
    repeat (6) tick();
    check("stray_ack_rsp", n_rsp, rs);
    check("stray_ack_req", req_count, rc);
    ack_delay = 0;

    // Response held for 10 cycles with commands waiting behind it
    rsp_ready = 1'b0;
    send(1'b0, 8'h03, 8'h00, 8'h5A, 1'b0);
    wait_valid(n);
    send(1'b1, 8'h30, 8'h77, 8'h00, 1'b0);
    send(1'b0, 8'h30, 8'h00, 8'h77, 1'b0);
    rc = req_count;
    repeat (10) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_data", rsp_data, 8'h5A);
      check("hold_err", rsp_err, 1'b0);
    end
    tick();
    check("hold_no_req", req_count, rc);
    rsp_ready = 1'b1;
    wait_drain("drain_t5");

    // Reset while in WAIT with two entries queued and an ack in flight
    ack_delay = 6;
    send(1'b0, 8'h11, 8'h00, 8'hB4, 1'b0);
    send(1'b1, 8'h40, 8'h01, 8'h00, 1'b0);
    send(1'b1, 8'h41, 8'h02, 8'h00, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    acc_q.delete();
    rc = req_count;
    rs = n_rsp;
    @(posedge clk);
    @(negedge clk);
    check_idle("rst_mid");
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1'b1);
    repeat (10) tick();
    check("rst_no_req", req_count, rc);
    check("rst_no_rsp", n_rsp, rs);
    ack_delay = 0;
    send(1'b0, 8'h03, 8'h00, 8'h5A, 1'b0);
    wait_valid(n);
    check("lat_after_rst", n, 3);
    wait_drain("drain_t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
